// File: rtl/synth_pkg.sv
// Shared synth definitions: sample/phase widths, waveform codes, per-voice
// configuration record and the voice scheduler state encoding.
package synth_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int WT_PHASE_W    = 10;
    localparam int VOICE_PHASE_W = 24;

    localparam logic [3:0] WAVE_SINE   = 4'd0;
    localparam logic [3:0] WAVE_SQUARE = 4'd1;

    typedef struct packed {
        logic [VOICE_PHASE_W-1:0] inc;
        logic [3:0]               wave;
        logic                     gate;
    } voice_cfg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } sched_state_t;

endpackage

// File: rtl/voice_tag_pipe.sv
// Delay line carrying {valid, gate} alongside a wavetable lookup so the mix
// accumulator knows which returning samples belong to a sounding voice.
module voice_tag_pipe #(
    parameter int WT_LATENCY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_in,
    input  logic gate_in,
    output logic vld_out,
    output logic gate_out
);

    logic [WT_LATENCY-1:0] vld_q;
    logic [WT_LATENCY-1:0] gate_q;

    // Valid bits are control and are flushed by reset so an aborted frame leaves nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_in;
            for (int i = 1; i < WT_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Gate bits only matter when qualified by valid, so they shift without reset.
    always_ff @(posedge clk) begin
        gate_q[0] <= gate_in;
        for (int i = 1; i < WT_LATENCY; i++) begin
            gate_q[i] <= gate_q[i-1];
        end
    end

    assign vld_out  = vld_q[WT_LATENCY-1];
    assign gate_out = gate_q[WT_LATENCY-1];

endmodule

// File: rtl/voice_scheduler.sv
// Walks all voices once per audio tick through the shared wavetable, advances
// gated phase accumulators and emits one saturated 16-bit mix per frame.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = VOICE_PHASE_W,
    parameter int WT_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_inc,
    input  logic [3:0]                    cfg_wave,
    input  logic                          cfg_gate,
    output logic [WT_PHASE_W-1:0]         wt_phase,
    output logic [3:0]                    wt_wave_select,
    input  logic signed [SAMPLE_W-1:0]    wt_sample,
    output logic signed [SAMPLE_W-1:0]    mix_sample,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int MIX_W  = SAMPLE_W + VIDX_W;
    // wt_phase is registered, so the last lookup reaches the wavetable one
    // cycle after its issue cycle; draining covers that extra cycle too.
    localparam int DRAIN_CYC = WT_LATENCY + 1;
    localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);

    localparam logic signed [MIX_W-1:0] SAT_HI = MIX_W'((1 <<< (SAMPLE_W - 1)) - 1);
    localparam logic signed [MIX_W-1:0] SAT_LO = MIX_W'(-(1 <<< (SAMPLE_W - 1)));

    function automatic logic signed [SAMPLE_W-1:0] sat_mix(input logic signed [MIX_W-1:0] x);
        if (x > SAT_HI) begin
            return SAT_HI[SAMPLE_W-1:0];
        end else if (x < SAT_LO) begin
            return SAT_LO[SAMPLE_W-1:0];
        end else begin
            return x[SAMPLE_W-1:0];
        end
    endfunction

    sched_state_t state, state_nxt;
    logic [VIDX_W-1:0] issue_cnt;
    logic [DCNT_W-1:0] drain_cnt;
    logic issue_en, out_en, tick_accept;

    voice_cfg_t        cfg_q [NUM_VOICES];
    logic [PHASE_W-1:0] acc_q [NUM_VOICES];

    logic tag_vld_p0, tag_gate_p0;
    logic tag_vld_pl, tag_gate_pl;
    logic signed [MIX_W-1:0] mix_acc;

    assign tick_accept = sample_tick && (state == S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one issue per voice, drain the lookup latency, then publish.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sample_tick) state_nxt = S_ISSUE;
            S_ISSUE:  if (issue_cnt == VIDX_W'(NUM_VOICES - 1)) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt == DCNT_W'(DRAIN_CYC - 1)) state_nxt = S_OUTPUT;
            S_OUTPUT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        issue_en = (state == S_ISSUE);
        out_en   = (state == S_OUTPUT);
        busy     = (state != S_IDLE);
    end

    // Issue and drain counters; issue_cnt wraps back to 0 after the last voice.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (issue_en) issue_cnt <= issue_cnt + VIDX_W'(1);
            if (state == S_DRAIN) drain_cnt <= drain_cnt + DCNT_W'(1);
            else                  drain_cnt <= '0;
        end
    end

    // Voice config and phase accumulators; a note-on clear overrides the issue advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                cfg_q[v] <= '0;
                acc_q[v] <= '0;
            end
        end else begin
            if (issue_en && cfg_q[issue_cnt].gate) begin
                acc_q[issue_cnt] <= acc_q[issue_cnt] + cfg_q[issue_cnt].inc;
            end
            if (cfg_we) begin
                cfg_q[cfg_voice] <= '{inc: cfg_inc, wave: cfg_wave, gate: cfg_gate};
                if (cfg_gate && !cfg_q[cfg_voice].gate) begin
                    acc_q[cfg_voice] <= '0;
                end
            end
        end
    end

    // Present the pre-update phase and wave to the wavetable; tag the lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            wt_phase       <= '0;
            wt_wave_select <= '0;
            tag_vld_p0     <= 1'b0;
            tag_gate_p0    <= 1'b0;
        end else begin
            tag_vld_p0  <= issue_en;
            tag_gate_p0 <= issue_en && cfg_q[issue_cnt].gate;
            if (issue_en) begin
                wt_phase       <= acc_q[issue_cnt][PHASE_W-1 -: WT_PHASE_W];
                wt_wave_select <= cfg_q[issue_cnt].wave;
            end
        end
    end

    voice_tag_pipe #(
        .WT_LATENCY (WT_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (tag_vld_p0),
        .gate_in  (tag_gate_p0),
        .vld_out  (tag_vld_pl),
        .gate_out (tag_gate_pl)
    );

    // Mix accumulation, saturated publish and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_acc    <= '0;
            mix_sample <= '0;
            mix_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mix_valid <= out_en;
            if (sample_tick && busy) overrun <= 1'b1;
            if (tick_accept) begin
                mix_acc <= '0;
            end else if (tag_vld_pl && tag_gate_pl) begin
                mix_acc <= mix_acc + MIX_W'(wt_sample);
            end
            if (out_en) mix_sample <= sat_mix(mix_acc);
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a 3-cycle wavetable model whose
// returned sample depends on the wave select that was presented.
module tb_voice_scheduler;
    import synth_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, sample_tick, cfg_we, cfg_gate;
    logic [2:0]         cfg_voice;
    logic [23:0]        cfg_inc;
    logic [3:0]         cfg_wave;
    logic [9:0]         wt_phase;
    logic [3:0]         wt_wave_select;
    logic signed [15:0] wt_sample, mix_sample;
    logic               mix_valid, busy, overrun;

    int errors = 0;
    int checks = 0;

    // Wavetable model: sample for a lookup appears three cycles after its phase is driven.
    logic [3:0]         wave_d1, wave_d2, wave_d3;
    logic signed [15:0] sq_val, other_val;
    always @(posedge clk) begin
        wave_d1 <= wt_wave_select;
        wave_d2 <= wave_d1;
        wave_d3 <= wave_d2;
    end
    assign wt_sample = (wave_d3 == WAVE_SQUARE) ? sq_val : other_val;

    voice_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .cfg_we         (cfg_we),
        .cfg_voice      (cfg_voice),
        .cfg_inc        (cfg_inc),
        .cfg_wave       (cfg_wave),
        .cfg_gate       (cfg_gate),
        .wt_phase       (wt_phase),
        .wt_wave_select (wt_wave_select),
        .wt_sample      (wt_sample),
        .mix_sample     (mix_sample),
        .mix_valid      (mix_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    task automatic cfg_write(input int v, input logic [23:0] inc, input logic [3:0] wave, input logic gate);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = 3'(v); cfg_inc = inc; cfg_wave = wave; cfg_gate = gate;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    // One frame: phase seen for voice 0, and cycles from the tick edge to mix_valid (-1 on timeout).
    task automatic run_frame(output logic [9:0] ph, output int lat);
        pulse_tick();
        lat = -1;
        ph = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) ph = wt_phase;
            if (mix_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
        cfg_inc = '0; cfg_wave = '0; cfg_gate = 1'b0;
        sq_val = '0; other_val = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL reset_mix_valid: got %b want 0", mix_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (mix_sample !== 16'h0000) begin errors++; $display("FAIL reset_mix_sample: got %h want 0000", mix_sample); end
        checks++; if (wt_phase !== 10'd0) begin errors++; $display("FAIL reset_wt_phase: got %0d want 0", wt_phase); end
        checks++; if (wt_wave_select !== 4'd0) begin errors++; $display("FAIL reset_wave_sel: got %0d want 0", wt_wave_select); end
    endtask

    task automatic test_phase_advance();
        logic [9:0] ph;
        int lat;
        cfg_write(0, 24'h004000, 4'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            pulse_tick();
            @(posedge clk); #1;
            ph = wt_phase;
            checks++; if (ph !== 10'(k)) begin errors++; $display("FAIL phase_v0_frame%0d: got %0d want %0d", k, ph, k); end
            checks++; if (wt_wave_select !== 4'd1) begin errors++; $display("FAIL wave_v0_frame%0d: got %0d want 1", k, wt_wave_select); end
            lat = -1;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                if (mix_valid) begin lat = n; break; end
            end
            checks++; if (lat < 0) begin errors++; $display("FAIL mix_timeout_frame%0d: got none want pulse", k); end
        end
    endtask

    task automatic test_silent_latency();
        logic [9:0] ph;
        int lat;
        cfg_write(0, 24'h004000, 4'd1, 1'b0);
        sq_val = 16'h1234; other_val = 16'h1234;
        for (int k = 0; k < 2; k++) begin
            run_frame(ph, lat);
            checks++; if (lat !== 13) begin errors++; $display("FAIL silent_latency%0d: got %0d want 13", k, lat); end
            checks++; if (mix_sample !== 16'h0000) begin errors++; $display("FAIL silent_mix%0d: got %h want 0000", k, mix_sample); end
        end
    endtask

    task automatic test_saturation();
        logic [9:0] ph;
        int lat;
        logic signed [15:0] vin  [3];
        logic signed [15:0] vexp [3];
        vin  = '{16'sh7FFF, 16'sh8000, 16'sh0100};
        vexp = '{16'sh7FFF, 16'sh8000, 16'sh0800};
        for (int v = 0; v < 8; v++) cfg_write(v, 24'h001000, WAVE_SQUARE, 1'b1);
        for (int k = 0; k < 3; k++) begin
            sq_val = vin[k];
            run_frame(ph, lat);
            checks++; if (mix_sample !== vexp[k]) begin errors++; $display("FAIL sat_mix%0d: got %h want %h", k, mix_sample, vexp[k]); end
        end
    endtask

    task automatic test_tag_alignment();
        logic [9:0] ph;
        int lat;
        for (int v = 0; v < 8; v++) cfg_write(v, 24'h0, WAVE_SINE, 1'b0);
        cfg_write(3, 24'h0, WAVE_SQUARE, 1'b1);
        sq_val = 16'h0100; other_val = 16'h2000;
        run_frame(ph, lat);
        checks++; if (mix_sample !== 16'h0100) begin errors++; $display("FAIL align_mix: got %h want 0100", mix_sample); end
    endtask

    task automatic test_phase_wrap();
        logic [9:0] ph;
        int lat;
        logic [9:0] pexp [3];
        pexp = '{10'd0, 10'd1023, 10'd1023};
        cfg_write(0, 24'hFFFFFF, WAVE_SINE, 1'b0);
        cfg_write(0, 24'hFFFFFF, WAVE_SINE, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_frame(ph, lat);
            checks++; if (ph !== pexp[k]) begin errors++; $display("FAIL wrap_phase%0d: got %0d want %0d", k, ph, pexp[k]); end
        end
        checks++; if (lat !== 13) begin errors++; $display("FAIL wrap_latency: got %0d want 13", lat); end
    endtask

    task automatic test_overrun();
        int pulses;
        pulse_tick();
        repeat (4) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b want 1", busy); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (mix_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] ph;
        int lat;
        int pulses;
        pulse_tick();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (mix_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
        checks++; if (mix_sample !== 16'h0000) begin errors++; $display("FAIL abort_mix_sample: got %h want 0000", mix_sample); end
        checks++; if (wt_phase !== 10'd0) begin errors++; $display("FAIL abort_wt_phase: got %0d want 0", wt_phase); end
        checks++; if (wt_wave_select !== 4'd0) begin errors++; $display("FAIL abort_wave_sel: got %0d want 0", wt_wave_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun: got %b want 0", overrun); end

        cfg_write(0, 24'h004000, WAVE_SINE, 1'b1);
        other_val = 16'h0123;
        run_frame(ph, lat);
        checks++; if (lat !== 13) begin errors++; $display("FAIL post_reset_latency: got %0d want 13", lat); end
        checks++; if (mix_sample !== 16'h0123) begin errors++; $display("FAIL post_reset_mix: got %h want 0123", mix_sample); end
        checks++; if (ph !== 10'd0) begin errors++; $display("FAIL post_reset_phase0: got %0d want 0", ph); end
        run_frame(ph, lat);
        checks++; if (ph !== 10'd1) begin errors++; $display("FAIL post_reset_phase1: got %0d want 1", ph); end

        cfg_write(0, 24'h004000, WAVE_SINE, 1'b0);
        cfg_write(0, 24'h004000, WAVE_SINE, 1'b1);
        run_frame(ph, lat);
        checks++; if (ph !== 10'd0) begin errors++; $display("FAIL note_on_clear: got %0d want 0", ph); end
    endtask

    initial begin
        test_reset();
        test_phase_advance();
        test_silent_latency();
        test_saturation();
        test_tag_alignment();
        test_phase_wrap();
        test_overrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
